// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage.
//   BR_OP_W : width of the branch condition code
//   br_op_t : the six legal branch conditions (010 and 011 are illegal)
package branch_pkg;

  localparam int BR_OP_W = 3;

  typedef enum logic [BR_OP_W-1:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_t;

  // Saturating increment shared by the statistics counters.
  function automatic logic sat_inc_en(input logic at_max, input logic inc);
    return inc && !at_max;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
//   br_op  : condition code (branch_pkg::br_op_t encoding)
//   op_a/b : compare operands, XLEN bits
//   taken  : condition true; illegal codes evaluate to 0
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic               taken
);

  logic eq, lt_s, lt_u;

  assign eq   = (op_a == op_b);
  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = !lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution stage: evaluates the branch condition, forms
// the redirect address, checks the front-end prediction and holds the result
// in a single registered slot with valid/ready handshake. Two saturating
// counters track resolved branches and mispredictions.
//   clk, rst_n                : clock, async active-low reset
//   in_valid/in_ready         : input handshake
//   br_op, op_a, op_b         : condition and operands
//   pc, imm                   : branch address and sign-extended offset
//   pred_taken, pred_target   : front-end prediction
//   flush                     : kill held result, block acceptance
//   out_valid/out_ready       : output handshake
//   taken, redirect_pc, mispredict : resolved result
//   clr_stats, br_count, mp_count  : statistics
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int ILEN_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    imm,
  input  logic               pred_taken,
  input  logic [XLEN-1:0]    pred_target,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               taken,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               mispredict,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   br_count,
  output logic [CNT_W-1:0]   mp_count
);

  logic            cond_taken;
  logic [XLEN-1:0] tgt_pc, seq_pc;
  logic            mp_calc;
  logic            accept, hs;

  logic             vld_q, vld_d;
  logic             taken_q;
  logic [XLEN-1:0]  rpc_q;
  logic             mp_q;
  logic [CNT_W-1:0] br_q, br_d, mp_cnt_q, mp_cnt_d;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .br_op (br_op),
    .op_a  (op_a),
    .op_b  (op_b),
    .taken (cond_taken)
  );

  // Modulo-2^XLEN address arithmetic; carries drop off the top.
  assign tgt_pc = pc + imm;
  assign seq_pc = pc + XLEN'(ILEN_BYTES);

  assign mp_calc = (cond_taken != pred_taken) ||
                   (cond_taken && pred_taken && (pred_target != tgt_pc));

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // Flush overrides the handshake, so a flushed result is never counted.
  assign hs       = vld_q && out_ready && !flush;

  always_comb begin
    vld_d = vld_q;
    if (flush)       vld_d = 1'b0;
    else if (accept) vld_d = 1'b1;
    else if (hs)     vld_d = 1'b0;
  end

  always_comb begin
    br_d     = br_q;
    mp_cnt_d = mp_cnt_q;
    if (clr_stats) begin
      br_d     = '0;
      mp_cnt_d = '0;
    end else begin
      if (sat_inc_en(&br_q, hs))            br_d     = br_q + 1'b1;
      if (sat_inc_en(&mp_cnt_q, hs && mp_q)) mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      taken_q  <= 1'b0;
      rpc_q    <= '0;
      mp_q     <= 1'b0;
      br_q     <= '0;
      mp_cnt_q <= '0;
    end else begin
      vld_q    <= vld_d;
      br_q     <= br_d;
      mp_cnt_q <= mp_cnt_d;
      if (accept) begin
        taken_q <= cond_taken;
        rpc_q   <= cond_taken ? tgt_pc : seq_pc;
        mp_q    <= mp_calc;
      end
    end
  end

  assign out_valid   = vld_q;
  assign taken       = taken_q;
  assign redirect_pc = rpc_q;
  assign mispredict  = mp_q;
  assign br_count    = br_q;
  assign mp_count    = mp_cnt_q;

endmodule
